// File: rtl/axis_merger_counted.sv
// Counted two-input AXI-Stream merger: takes FROM_PORT_ZERO beats from input 0,
// then FROM_PORT_ONE beats from input 1, through a single registered output stage.
module axis_merger_counted #(
    parameter int DATA_WIDTH     = 16,
    parameter int FROM_PORT_ZERO = 17,
    parameter int FROM_PORT_ONE  = 5
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  input_0_valid,
    input  logic [DATA_WIDTH-1:0] input_0_data,
    output logic                  input_0_ready,

    input  logic                  input_1_valid,
    input  logic [DATA_WIDTH-1:0] input_1_data,
    output logic                  input_1_ready,

    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    input  logic                  output_ready,
    output logic                  output_last
);

    localparam int MAX_N = (FROM_PORT_ZERO > FROM_PORT_ONE) ? FROM_PORT_ZERO : FROM_PORT_ONE;
    localparam int CW    = $clog2(MAX_N + 1);

    localparam logic HAS_0 = (FROM_PORT_ZERO != 0);
    localparam logic HAS_1 = (FROM_PORT_ONE != 0);

    // Empty groups never get selected, so their terminal count is a don't-care.
    localparam logic [CW-1:0] LAST_0 = (FROM_PORT_ZERO > 0) ? CW'(FROM_PORT_ZERO - 1) : '0;
    localparam logic [CW-1:0] LAST_1 = (FROM_PORT_ONE > 0)  ? CW'(FROM_PORT_ONE - 1)  : '0;

    typedef enum logic {
        PORT_0,
        PORT_1
    } state_t;

    localparam state_t START = HAS_0 ? PORT_0 : PORT_1;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic                    out_free;
    logic                    take_0;
    logic                    take_1;
    logic                    grp_end;

    assign out_free      = !out_valid_q || output_ready;
    assign input_0_ready = !rst && HAS_0 && (state_q == PORT_0) && out_free;
    assign input_1_ready = !rst && HAS_1 && (state_q == PORT_1) && out_free;

    assign take_0  = input_0_valid && input_0_ready;
    assign take_1  = input_1_valid && input_1_ready;
    assign grp_end = take_0 ? (cnt_q == LAST_0) : (cnt_q == LAST_1);

    assign output_valid = out_valid_q;
    assign output_data  = out_data_q;
    assign output_last  = out_last_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        if (take_0 || take_1) begin
            out_valid_d = 1'b1;
            out_data_d  = take_0 ? input_0_data : input_1_data;
            if (grp_end) begin
                cnt_d = '0;
                // A round ends after port 1's group, or after port 0's when port 1 is empty.
                if (take_0) begin
                    state_d    = HAS_1 ? PORT_1 : PORT_0;
                    out_last_d = !HAS_1;
                end else begin
                    state_d    = HAS_0 ? PORT_0 : PORT_1;
                    out_last_d = 1'b1;
                end
            end else begin
                cnt_d      = cnt_q + CW'(1);
                out_last_d = 1'b0;
            end
        end else if (output_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= START;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule

// File: tb/tb_axis_merger_counted.sv
// Directed bench for axis_merger_counted: default 17/5 sizing, 1/1 sizing and 17/0 sizing.
module tb_axis_merger_counted;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // DUT A: default sizing 17/5
    logic        a_v0, a_r0, a_v1, a_r1, a_ov, a_ordy, a_ol;
    logic [15:0] a_d0, a_d1, a_od;
    // DUT B: 1/1
    logic        b_v0, b_r0, b_v1, b_r1, b_ov, b_ordy, b_ol;
    logic [15:0] b_d0, b_d1, b_od;
    // DUT C: 17/0
    logic        c_v0, c_r0, c_v1, c_r1, c_ov, c_ordy, c_ol;
    logic [15:0] c_d0, c_d1, c_od;

    axis_merger_counted dut_a (
        .clk(clk), .rst(rst),
        .input_0_valid(a_v0), .input_0_data(a_d0), .input_0_ready(a_r0),
        .input_1_valid(a_v1), .input_1_data(a_d1), .input_1_ready(a_r1),
        .output_valid(a_ov), .output_data(a_od), .output_ready(a_ordy), .output_last(a_ol)
    );

    axis_merger_counted #(.DATA_WIDTH(16), .FROM_PORT_ZERO(1), .FROM_PORT_ONE(1)) dut_b (
        .clk(clk), .rst(rst),
        .input_0_valid(b_v0), .input_0_data(b_d0), .input_0_ready(b_r0),
        .input_1_valid(b_v1), .input_1_data(b_d1), .input_1_ready(b_r1),
        .output_valid(b_ov), .output_data(b_od), .output_ready(b_ordy), .output_last(b_ol)
    );

    axis_merger_counted #(.DATA_WIDTH(16), .FROM_PORT_ZERO(17), .FROM_PORT_ONE(0)) dut_c (
        .clk(clk), .rst(rst),
        .input_0_valid(c_v0), .input_0_data(c_d0), .input_0_ready(c_r0),
        .input_1_valid(c_v1), .input_1_data(c_d1), .input_1_ready(c_r1),
        .output_valid(c_ov), .output_data(c_od), .output_ready(c_ordy), .output_last(c_ol)
    );

    // Reference for DUT A: beats accepted per port plus the expected output register.
    int          i0, i1;
    logic        m_ov, m_ol;
    logic [15:0] m_od;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        a_v0 = 1'b0; a_v1 = 1'b0; a_d0 = '0; a_d1 = '0; a_ordy = 1'b1;
        b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = '0; b_d1 = '0; b_ordy = 1'b1;
        c_v0 = 1'b0; c_v1 = 1'b0; c_d0 = '0; c_d1 = '0; c_ordy = 1'b1;
    endtask

    task automatic release_reset();
        idle_inputs();
        rst  = 1'b0;
        i0   = 0;
        i1   = 0;
        m_ov = 1'b0;
        m_od = '0;
        m_ol = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("rst_a_valid", a_ov, 1'b0);
        chk("rst_a_data",  a_od, 16'd0);
        chk("rst_a_last",  a_ol, 1'b0);
        chk("rst_a_rdy0",  a_r0, 1'b0);
        chk("rst_a_rdy1",  a_r1, 1'b0);
        chk("rst_b_valid", b_ov, 1'b0);
        chk("rst_c_valid", c_ov, 1'b0);
        @(negedge clk);
        release_reset();
    endtask

    // rmode: 0 = output_ready high, 1 = toggles every 2 cycles, 2 = held low.
    task automatic run_a(input int ncyc, input int p0_start, input int rmode);
        logic sel0, free, r0e, r1e, ordy;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge clk);
            ordy   = (rmode == 0) ? 1'b1 : (rmode == 1) ? ((cyc / 2) % 2 == 0) : 1'b0;
            a_ordy = ordy;
            a_v0   = (cyc >= p0_start);
            a_d0   = 16'(i0);
            a_v1   = 1'b1;
            a_d1   = 16'(100 + i1);
            #1;
            sel0 = (i0 < 17 * (i1 / 5 + 1));
            free = !m_ov || ordy;
            r0e  = sel0 && free;
            r1e  = !sel0 && free;
            chk("a_in0_ready", a_r0, r0e);
            chk("a_in1_ready", a_r1, r1e);
            chk("a_out_valid", a_ov, m_ov);
            if (m_ov) begin
                chk("a_out_data", a_od, m_od);
                chk("a_out_last", a_ol, m_ol);
            end
            if (a_v0 && r0e) begin
                m_od = 16'(i0); m_ol = 1'b0; m_ov = 1'b1; i0++;
            end else if (r1e) begin
                m_od = 16'(100 + i1); m_ol = (i1 % 5 == 4); m_ov = 1'b1; i1++;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
        end
    endtask

    initial begin
        logic [15:0] b_in0 [2];
        logic [15:0] b_in1 [2];
        logic [15:0] b_exp [4];
        logic        b_lst [4];
        int j0, j1, nb, k0, nc, n_r1;

        idle_inputs();
        i0 = 0; i1 = 0; m_ov = 1'b0; m_od = '0; m_ol = 1'b0;
        repeat (2) @(negedge clk);
        release_reset();

        // Full-rate merge over two rounds, then stalled output, then a late port 0.
        run_a(50, 0, 0);
        run_a(60, 0, 1);
        do_reset();
        run_a(40, 10, 0);

        // Async reset while the output is stalled after 8 port-0 beats.
        do_reset();
        run_a(8, 0, 0);
        run_a(1, 0, 2);
        @(negedge clk);
        #1;
        chk("pre_rst_valid", a_ov, 1'b1);
        chk("pre_rst_data",  a_od, 16'd7);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", a_ov, 1'b0);
        chk("async_rst_rdy0",  a_r0, 1'b0);
        @(negedge clk);
        release_reset();
        run_a(30, 0, 0);

        // 1/1 sizing: A0,B0,A1,B1 with last on each port-1 beat.
        do_reset();
        b_in0[0] = 16'hA0; b_in0[1] = 16'hA1;
        b_in1[0] = 16'hB0; b_in1[1] = 16'hB1;
        b_exp[0] = 16'hA0; b_exp[1] = 16'hB0; b_exp[2] = 16'hA1; b_exp[3] = 16'hB1;
        b_lst[0] = 1'b0;   b_lst[1] = 1'b1;   b_lst[2] = 1'b0;   b_lst[3] = 1'b1;
        j0 = 0; j1 = 0; nb = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            b_ordy = 1'b1;
            b_v0 = (j0 < 2); b_d0 = b_in0[j0 % 2];
            b_v1 = (j1 < 2); b_d1 = b_in1[j1 % 2];
            #1;
            if (b_ov && b_ordy) begin
                if (nb < 4) begin
                    chk("b_data", b_od, b_exp[nb]);
                    chk("b_last", b_ol, b_lst[nb]);
                end
                nb++;
            end
            if (b_v0 && b_r0) j0++;
            if (b_v1 && b_r1) j1++;
        end
        chk("b_beats", nb, 4);

        // 17/0 sizing: port 1 never ready, last on every 17th beat.
        do_reset();
        k0 = 0; nc = 0; n_r1 = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            c_ordy = 1'b1;
            c_v0 = 1'b1; c_d0 = 16'(k0);
            c_v1 = 1'b1; c_d1 = 16'hBEEF;
            #1;
            if (c_r1) n_r1++;
            if (c_ov) begin
                chk("c_data", c_od, 16'(nc));
                chk("c_last", c_ol, (nc % 17 == 16));
                nc++;
            end
            if (c_v0 && c_r0) k0++;
        end
        chk("c_rdy1_never", n_r1, 0);
        chk("c_beats", nc, 39);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
